// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit direction counters and resolve-side redirect
module branch_predictor #(
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] fetch_pc_in,
  output logic        predict_hit_out,
  output logic        predict_taken_out,
  output logic [31:0] predict_target_out,
  input  logic        resolve_valid_in,
  input  logic [31:0] resolve_pc_in,
  input  logic [4:0]  resolve_opcode_6_to_2_in,
  input  logic        branch_taken_in,
  input  logic [31:0] resolve_target_in,
  input  logic        predicted_taken_in,
  input  logic [31:0] predicted_target_in,
  output logic        mispredict_out,
  output logic [31:0] redirect_pc_out,
  output logic [15:0] branch_count_out,
  output logic [15:0] mispredict_count_out
);

  localparam int TAG_BITS = 32 - INDEX_BITS - 2;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic [INDEX_BITS-1:0] res_idx;
  logic [TAG_BITS-1:0]   res_tag;
  logic                  is_branch;
  logic                  is_jal;
  logic                  train;
  logic                  hit_r;
  logic                  actual_taken;
  logic [31:0]           actual_next;
  logic                  mispredict_now;

  // Lookup reads the pre-update table; same-cycle writes are not forwarded.
  always_comb begin
    fetch_idx          = fetch_pc_in[INDEX_BITS+1:2];
    fetch_tag          = fetch_pc_in[31:INDEX_BITS+2];
    predict_hit_out    = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    predict_taken_out  = predict_hit_out && ctr_q[fetch_idx][1];
    predict_target_out = predict_hit_out ? target_q[fetch_idx] : fetch_pc_in + 32'd4;
  end

  always_comb begin
    res_idx        = resolve_pc_in[INDEX_BITS+1:2];
    res_tag        = resolve_pc_in[31:INDEX_BITS+2];
    is_branch      = (resolve_opcode_6_to_2_in == OP_BRANCH);
    is_jal         = (resolve_opcode_6_to_2_in == OP_JAL);
    train          = resolve_valid_in && (is_branch || is_jal);
    hit_r          = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    actual_taken   = is_jal || branch_taken_in;
    actual_next    = actual_taken ? resolve_target_in : resolve_pc_in + 32'd4;
    mispredict_now = train && ((actual_taken != predicted_taken_in) ||
                               (actual_taken && (resolve_target_in != predicted_target_in)));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q              <= '0;
      mispredict_out       <= 1'b0;
      redirect_pc_out      <= 32'd0;
      branch_count_out     <= 16'd0;
      mispredict_count_out <= 16'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      mispredict_out <= mispredict_now;
      if (mispredict_now) begin
        redirect_pc_out      <= actual_next;
        mispredict_count_out <= mispredict_count_out + 16'd1;
      end
      if (train) begin
        branch_count_out <= branch_count_out + 16'd1;
        if (is_jal) begin
          valid_q[res_idx]  <= 1'b1;
          tag_q[res_idx]    <= res_tag;
          target_q[res_idx] <= resolve_target_in;
          ctr_q[res_idx]    <= 2'b11;
        end else if (hit_r) begin
          if (branch_taken_in) begin
            target_q[res_idx] <= resolve_target_in;
            if (ctr_q[res_idx] != 2'b11) ctr_q[res_idx] <= ctr_q[res_idx] + 2'd1;
          end else if (ctr_q[res_idx] != 2'b00) begin
            ctr_q[res_idx] <= ctr_q[res_idx] - 2'd1;
          end
        end else if (branch_taken_in) begin
          // Taken miss evicts whatever alias occupied the slot.
          valid_q[res_idx]  <= 1'b1;
          tag_q[res_idx]    <= res_tag;
          target_q[res_idx] <= resolve_target_in;
          ctr_q[res_idx]    <= 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed-vector bench for branch_predictor
module tb_branch_predictor;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] fetch_pc_in;
  logic        predict_hit_out;
  logic        predict_taken_out;
  logic [31:0] predict_target_out;
  logic        resolve_valid_in;
  logic [31:0] resolve_pc_in;
  logic [4:0]  resolve_opcode_6_to_2_in;
  logic        branch_taken_in;
  logic [31:0] resolve_target_in;
  logic        predicted_taken_in;
  logic [31:0] predicted_target_in;
  logic        mispredict_out;
  logic [31:0] redirect_pc_out;
  logic [15:0] branch_count_out;
  logic [15:0] mispredict_count_out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [4:0] BR  = 5'b11000;
  localparam logic [4:0] JAL = 5'b11011;
  localparam logic [4:0] OPR = 5'b01100;

  branch_predictor #(.ENTRIES(16), .INDEX_BITS(4)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .fetch_pc_in(fetch_pc_in),
    .predict_hit_out(predict_hit_out),
    .predict_taken_out(predict_taken_out),
    .predict_target_out(predict_target_out),
    .resolve_valid_in(resolve_valid_in),
    .resolve_pc_in(resolve_pc_in),
    .resolve_opcode_6_to_2_in(resolve_opcode_6_to_2_in),
    .branch_taken_in(branch_taken_in),
    .resolve_target_in(resolve_target_in),
    .predicted_taken_in(predicted_taken_in),
    .predicted_target_in(predicted_target_in),
    .mispredict_out(mispredict_out),
    .redirect_pc_out(redirect_pc_out),
    .branch_count_out(branch_count_out),
    .mispredict_count_out(mispredict_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One resolve per call; outputs are sampled 1ns after the training edge.
  task automatic resolve(input logic [31:0] pc, input logic [4:0] op, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    resolve_valid_in         = 1'b1;
    resolve_pc_in            = pc;
    resolve_opcode_6_to_2_in = op;
    branch_taken_in          = tk;
    resolve_target_in        = tgt;
    predicted_taken_in       = ptk;
    predicted_target_in      = ptgt;
    @(posedge clk_in);
    #1;
    resolve_valid_in = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] tgt);
    fetch_pc_in = pc;
    #1;
    check({tag, "_hit"}, 32'(predict_hit_out), 32'(hit));
    check({tag, "_taken"}, 32'(predict_taken_out), 32'(tk));
    check({tag, "_target"}, predict_target_out, tgt);
  endtask

  task automatic check_mp(input string tag, input logic mp, input logic [31:0] rd,
                          input logic [15:0] bc, input logic [15:0] mc);
    check({tag, "_mp"}, 32'(mispredict_out), 32'(mp));
    check({tag, "_redirect"}, redirect_pc_out, rd);
    check({tag, "_bcount"}, 32'(branch_count_out), 32'(bc));
    check({tag, "_mcount"}, 32'(mispredict_count_out), 32'(mc));
  endtask

  initial begin
    rst_in = 1'b1;
    fetch_pc_in = 32'h0;
    resolve_valid_in = 1'b0;
    resolve_pc_in = 32'h0;
    resolve_opcode_6_to_2_in = 5'b0;
    branch_taken_in = 1'b0;
    resolve_target_in = 32'h0;
    predicted_taken_in = 1'b0;
    predicted_target_in = 32'h0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    lookup("reset_lk", 32'h100, 1'b0, 1'b0, 32'h104);
    check_mp("reset", 1'b0, 32'h0, 16'd0, 16'd0);

    // Taken miss allocates with ctr=10 and mispredicts.
    resolve(32'h100, BR, 1'b1, 32'h200, 1'b0, 32'h104);
    check_mp("alloc", 1'b1, 32'h200, 16'd1, 16'd1);
    lookup("alloc_lk", 32'h100, 1'b1, 1'b1, 32'h200);
    @(posedge clk_in); #1;
    check_mp("idle_hold", 1'b0, 32'h200, 16'd1, 16'd1);

    // Up to 11, saturates there.
    resolve(32'h100, BR, 1'b1, 32'h200, 1'b1, 32'h200);
    check_mp("tk2", 1'b0, 32'h200, 16'd2, 16'd1);
    resolve(32'h100, BR, 1'b1, 32'h200, 1'b1, 32'h200);
    check_mp("tk3", 1'b0, 32'h200, 16'd3, 16'd1);
    lookup("sat_hi_lk", 32'h100, 1'b1, 1'b1, 32'h200);

    // Three back-to-back not-taken mispredicts: 11 -> 10 -> 01 -> 00.
    resolve(32'h100, BR, 1'b0, 32'h200, 1'b1, 32'h200);
    check_mp("nt1", 1'b1, 32'h104, 16'd4, 16'd2);
    lookup("nt1_lk", 32'h100, 1'b1, 1'b1, 32'h200);
    resolve(32'h100, BR, 1'b0, 32'h200, 1'b1, 32'h200);
    check_mp("nt2", 1'b1, 32'h104, 16'd5, 16'd3);
    lookup("nt2_lk", 32'h100, 1'b1, 1'b0, 32'h200);
    resolve(32'h100, BR, 1'b0, 32'h200, 1'b1, 32'h200);
    check_mp("nt3", 1'b1, 32'h104, 16'd6, 16'd4);
    resolve(32'h100, BR, 1'b0, 32'h200, 1'b0, 32'h104);
    check_mp("nt4", 1'b0, 32'h104, 16'd7, 16'd4);
    // One taken from 00 must reach only 01.
    resolve(32'h100, BR, 1'b1, 32'h200, 1'b0, 32'h104);
    check_mp("sat_lo_tk", 1'b1, 32'h200, 16'd8, 16'd5);
    lookup("sat_lo_lk", 32'h100, 1'b1, 1'b0, 32'h200);

    // Not-taken miss: no allocation, no mispredict, still counted.
    resolve(32'h300, BR, 1'b0, 32'h400, 1'b0, 32'h304);
    check_mp("nt_miss", 1'b0, 32'h200, 16'd9, 16'd5);
    lookup("nt_miss_lk", 32'h300, 1'b0, 1'b0, 32'h304);

    // Direction right, target wrong; hit updates target, ctr 01 -> 10.
    resolve(32'h100, BR, 1'b1, 32'h240, 1'b1, 32'h200);
    check_mp("tgt_mp", 1'b1, 32'h240, 16'd10, 16'd6);
    lookup("tgt_lk", 32'h100, 1'b1, 1'b1, 32'h240);

    // JAL alias at 0x100 + 4*16 with branch_taken_in low.
    resolve(32'h140, JAL, 1'b0, 32'h500, 1'b0, 32'h144);
    check_mp("jal", 1'b1, 32'h500, 16'd11, 16'd7);
    lookup("alias_old_lk", 32'h100, 1'b0, 1'b0, 32'h104);
    lookup("alias_new_lk", 32'h140, 1'b1, 1'b1, 32'h500);
    resolve(32'h140, BR, 1'b0, 32'h500, 1'b1, 32'h500);
    check_mp("jal_ctr", 1'b1, 32'h144, 16'd12, 16'd8);
    lookup("jal_ctr_lk", 32'h140, 1'b1, 1'b1, 32'h500);

    // Reset wins over a same-cycle mispredicting resolve.
    rst_in = 1'b1;
    resolve(32'h100, BR, 1'b1, 32'h200, 1'b0, 32'h104);
    rst_in = 1'b0;
    check_mp("rst_res", 1'b0, 32'h0, 16'd0, 16'd0);
    lookup("rst_lk", 32'h140, 1'b0, 1'b0, 32'h144);

    // Non-branch opcode is ignored entirely.
    resolve(32'h100, OPR, 1'b1, 32'h600, 1'b0, 32'h104);
    check_mp("opr", 1'b0, 32'h0, 16'd0, 16'd0);
    lookup("opr_lk", 32'h100, 1'b0, 1'b0, 32'h104);

    // Fall-through next-PC wraps modulo 2^32.
    resolve(32'hFFFF_FFFC, BR, 1'b0, 32'h10, 1'b1, 32'h10);
    check_mp("wrap", 1'b1, 32'h0, 16'd1, 16'd1);
    @(posedge clk_in); #1;
    check_mp("wrap_idle", 1'b0, 32'h0, 16'd1, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
